// File: rtl/man_encode_frame_pkg.sv
// Shared definitions for the Manchester frame encoder: line-convention
// selectors, the FSM state type and the half-bit level helper.
package man_pkg;

  // Line-convention selector values for the IEEE_MODE parameter.
  localparam int MAN_IEEE   = 1;
  localparam int MAN_THOMAS = 0;

  // Encoder FSM: waiting for a word, or driving a frame on the line.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } man_state_e;

  // Line level for one half of a Manchester bit.
  // IEEE 802.3 sends the complement of the bit first (1 = low then high);
  // G.E. Thomas sends the bit itself first (1 = high then low).
  // The second half is always the complement of the first half.
  function automatic logic man_half(input logic b, input logic ieee, input logic phase);
    logic first;
    first = ieee ? ~b : b;
    return phase ? ~first : first;
  endfunction

endpackage

// File: rtl/man_encode_frame_timer.sv
// Half-bit timer: counts clk cycles inside each half of a Manchester bit
// and flags the last cycle of every half-bit.
module man_half_bit_timer #(
  parameter int HALF_BIT_CLKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic half_tick,
  output logic half_tick_next
);

  localparam int CW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT_CLKS - 1);

  logic [CW-1:0] half_cnt_q;
  logic [CW-1:0] half_cnt_d;

  // Count while a frame runs, wrap at the end of each half-bit, and park at
  // zero when idle so a new frame always starts on a fresh half-bit.
  always_comb begin
    half_cnt_d = '0;
    if (run && (half_cnt_q != HALF_LAST)) begin
      half_cnt_d = half_cnt_q + CW'(1);
    end
  end

  // Half-bit counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_q <= '0;
    end else begin
      half_cnt_q <= half_cnt_d;
    end
  end

  assign half_tick = run && (half_cnt_q == HALF_LAST);

  // Lets the frame logic compute registered flags one cycle ahead; the
  // caller qualifies it with whether the timer will still be running.
  assign half_tick_next = (half_cnt_d == HALF_LAST);

endmodule

// File: rtl/man_encode_frame.sv
// Manchester frame encoder: accepts DATA_W-bit words over valid/ready and
// drives them bit-serially as Manchester half-bits, with back-to-back frames
// running gaplessly and a defined line level between frames.
module man_encode_frame
  import man_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int HALF_BIT_CLKS = 4,
  parameter int MSB_FIRST     = 1,
  parameter int IEEE_MODE     = 1,
  parameter int IDLE_LEVEL    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              man_out,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic IEEE_SEL = (IEEE_MODE == MAN_IEEE);
  localparam logic IDLE_LVL = (IDLE_LEVEL != 0);
  localparam logic MSB_SEL  = (MSB_FIRST != 0);

  man_state_e        state_q, state_d;
  logic              phase_q, phase_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              man_out_q, man_out_d;
  logic              tx_active_q, tx_active_d;
  logic              frame_done_q, frame_done_d;

  logic half_tick;
  logic half_tick_next;
  logic last_cycle;
  logic accept;

  // The bit currently on the line always sits at the leading end of the
  // shift register, so only one end of it is ever inspected.
  function automatic logic lead_bit(input logic [DATA_W-1:0] w);
    return MSB_SEL ? w[DATA_W-1] : w[0];
  endfunction

  // Move the next bit to the leading end.
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_SEL ? (w << 1) : (w >> 1);
  endfunction

  man_half_bit_timer #(
    .HALF_BIT_CLKS(HALF_BIT_CLKS)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (state_q == SEND),
    .half_tick     (half_tick),
    .half_tick_next(half_tick_next)
  );

  // The final clk of the final half-bit is the only point inside a frame
  // where a new word can be taken, which gives gapless back-to-back frames.
  assign last_cycle = (state_q == SEND) && (bit_cnt_q == BIT_LAST) && phase_q && half_tick;
  assign tx_ready   = (state_q == IDLE) || last_cycle;
  assign accept     = tx_valid && tx_ready;

  // Next-state logic: load a word on handshake, step phase/bit on half-bit
  // boundaries, and compute the line level for the following cycle.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    man_out_d   = man_out_q;
    tx_active_d = tx_active_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = SEND;
          phase_d     = 1'b0;
          bit_cnt_d   = '0;
          shift_d     = tx_data;
          man_out_d   = man_half(lead_bit(tx_data), IEEE_SEL, 1'b0);
          tx_active_d = 1'b1;
        end else begin
          man_out_d   = IDLE_LVL;
          tx_active_d = 1'b0;
        end
      end

      SEND: begin
        if (half_tick) begin
          if (!phase_q) begin
            phase_d   = 1'b1;
            man_out_d = man_half(lead_bit(shift_q), IEEE_SEL, 1'b1);
          end else if (bit_cnt_q == BIT_LAST) begin
            if (accept) begin
              phase_d     = 1'b0;
              bit_cnt_d   = '0;
              shift_d     = tx_data;
              man_out_d   = man_half(lead_bit(tx_data), IEEE_SEL, 1'b0);
              tx_active_d = 1'b1;
            end else begin
              state_d     = IDLE;
              phase_d     = 1'b0;
              bit_cnt_d   = '0;
              shift_d     = '0;
              man_out_d   = IDLE_LVL;
              tx_active_d = 1'b0;
            end
          end else begin
            phase_d   = 1'b0;
            bit_cnt_d = bit_cnt_q + BW'(1);
            shift_d   = advance(shift_q);
            man_out_d = man_half(lead_bit(advance(shift_q)), IEEE_SEL, 1'b0);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // frame_done is registered, so it must rise when the counters are about
    // to enter the final cycle of the frame.
    frame_done_d = (state_d == SEND) && (bit_cnt_d == BIT_LAST) && phase_d && half_tick_next;
  end

  // FSM, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      man_out_q    <= IDLE_LVL;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      man_out_q    <= man_out_d;
      tx_active_q  <= tx_active_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign man_out    = man_out_q;
  assign tx_active  = tx_active_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_man_encode_frame.sv
// Self-checking bench for man_encode_frame: three differently configured
// encoders are driven by independent producers and compared every cycle
// against a frame-position model, with literal waveforms pinning the model.
module tb_man_encode_frame;
   import man_pkg::*;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [NI-1:0] txValid = '0;
   logic [NI-1:0] txReady;
   logic [NI-1:0] manOut;
   logic [NI-1:0] txActive;
   logic [NI-1:0] frameDone;
   logic [7:0] txData [NI];

   int checks = 0;
   int errors = 0;
   logic timeoutFlag = 1'b0;

   int k [NI] = '{-1, -1, -1};
   logic [7:0] mWord [NI];

   logic [NI-1:0] pinArm = '0;
   logic [31:0] pinSeq [NI];
   int pinLen [NI];

   man_encode_frame #(.DATA_W(8), .HALF_BIT_CLKS(2), .MSB_FIRST(1), .IEEE_MODE(MAN_IEEE), .IDLE_LEVEL(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .tx_data(txData[0]), .tx_valid(txValid[0]), .tx_ready(txReady[0]),
      .man_out(manOut[0]), .tx_active(txActive[0]), .frame_done(frameDone[0]));

   man_encode_frame #(.DATA_W(8), .HALF_BIT_CLKS(1), .MSB_FIRST(0), .IEEE_MODE(MAN_THOMAS), .IDLE_LEVEL(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data(txData[1]), .tx_valid(txValid[1]), .tx_ready(txReady[1]),
      .man_out(manOut[1]), .tx_active(txActive[1]), .frame_done(frameDone[1]));

   man_encode_frame #(.DATA_W(1), .HALF_BIT_CLKS(3), .MSB_FIRST(1), .IEEE_MODE(MAN_IEEE), .IDLE_LEVEL(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data(txData[2][0:0]), .tx_valid(txValid[2]), .tx_ready(txReady[2]),
      .man_out(manOut[2]), .tx_active(txActive[2]), .frame_done(frameDone[2]));

   // Free-running clock, 10 time units per cycle.
   initial forever #5 clk = ~clk;

   function automatic int cfgW(input int i);
      case (i)
         0: return 8;
         1: return 8;
         default: return 1;
      endcase
   endfunction

   function automatic int cfgH(input int i);
      case (i)
         0: return 2;
         1: return 1;
         default: return 3;
      endcase
   endfunction

   function automatic bit cfgMsb(input int i);
      return (i != 1);
   endfunction

   function automatic bit cfgIeee(input int i);
      return (i != 1);
   endfunction

   function automatic logic cfgIdle(input int i);
      return (i == 1);
   endfunction

   function automatic int frameLen(input int i);
      return 2 * cfgH(i) * cfgW(i);
   endfunction

   function automatic bit modelReady(input int i, input int kv);
      return (kv < 0) || (kv == frameLen(i) - 1);
   endfunction

   // Expected line level at position kv of a frame carrying word w: pick the
   // bit from the position, then apply the convention for that half.
   function automatic logic expLevel(input int i, input logic [7:0] w, input int kv);
      int bitIdx;
      int half;
      int bitPos;
      logic b;
      logic first;
      bitIdx = kv / (2 * cfgH(i));
      half   = (kv / cfgH(i)) % 2;
      bitPos = cfgMsb(i) ? (cfgW(i) - 1 - bitIdx) : bitIdx;
      b      = w[bitPos];
      first  = cfgIeee(i) ? ~b : b;
      return (half == 1) ? ~first : first;
   endfunction

   // Model: track each encoder's position inside its current frame; a word
   // is taken whenever the producer offers one and the model says ready.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) k[i] <= -1;
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (txValid[i] && modelReady(i, k[i])) begin
               k[i] <= 0;
               mWord[i] <= txData[i];
            end else if (k[i] >= 0) begin
               k[i] <= (k[i] + 1 == frameLen(i)) ? -1 : k[i] + 1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int inst, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s inst%0d t=%0t got %b required %b", name, inst, $time, actual, expected);
      end
   endtask

   // Compare every output of every encoder against the model mid-cycle.
   always @(negedge clk) begin
      checkOutput("watchdog", 0, timeoutFlag, 1'b0);
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            checkOutput("rst_man_out", i, manOut[i], cfgIdle(i));
            checkOutput("rst_tx_active", i, txActive[i], 1'b0);
            checkOutput("rst_frame_done", i, frameDone[i], 1'b0);
         end else begin
            checkOutput("man_out", i, manOut[i], (k[i] >= 0) ? expLevel(i, mWord[i], k[i]) : cfgIdle(i));
            checkOutput("tx_active", i, txActive[i], k[i] >= 0);
            checkOutput("frame_done", i, frameDone[i], k[i] == frameLen(i) - 1);
            checkOutput("tx_ready", i, txReady[i], modelReady(i, k[i]));
            if (pinArm[i] && k[i] >= 0) begin
               checkOutput("pin_man_out", i, manOut[i], pinSeq[i][pinLen[i] - 1 - k[i]]);
               checkOutput("pin_frame_done", i, frameDone[i], k[i] == pinLen[i] - 1);
            end
         end
      end
   end

   task automatic waitReady(input int i);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (txReady[i]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         $display("[TB] FAIL wait_ready inst%0d got no ready required ready within 200 cycles", i);
         timeoutFlag = 1'b1;
      end
   endtask

   task automatic waitIdle(input int i);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (k[i] < 0) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         $display("[TB] FAIL wait_idle inst%0d got busy required idle within 300 cycles", i);
         timeoutFlag = 1'b1;
      end
   endtask

   task automatic sendWord(input int i, input logic [7:0] w);
      @(posedge clk); #1;
      txValid[i] = 1'b1;
      txData[i] = w;
      waitReady(i);
      @(posedge clk); #1;
      txValid[i] = 1'b0;
   endtask

   task automatic applyStimulus();
      logic [NI-1:0] accSeen;

      // Directed 0xA5, IEEE, MSB first, two clks per half-bit.
      pinSeq[0] = 32'h3C3C_C3C3;
      pinLen[0] = 32;
      pinArm[0] = 1'b1;
      sendWord(0, 8'hA5);
      waitIdle(0);
      pinArm[0] = 1'b0;

      // Directed 0x01, Thomas, LSB first, one clk per half-bit, idle high.
      pinSeq[1] = 32'h0000_9555;
      pinLen[1] = 16;
      pinArm[1] = 1'b1;
      sendWord(1, 8'h01);
      waitIdle(1);
      pinArm[1] = 1'b0;

      // Directed single-bit frame: a 1 under IEEE is three lows then three highs.
      pinSeq[2] = 32'h0000_0007;
      pinLen[2] = 6;
      pinArm[2] = 1'b1;
      sendWord(2, 8'h01);
      waitIdle(2);
      pinArm[2] = 1'b0;

      // Back-to-back 0xFF then 0x00 with valid held high throughout.
      @(posedge clk); #1;
      txValid[0] = 1'b1;
      txData[0] = 8'hFF;
      waitReady(0);
      @(posedge clk); #1;
      txData[0] = 8'h00;
      waitReady(0);
      @(posedge clk); #1;
      txValid[0] = 1'b0;
      waitIdle(0);

      // Reset in the middle of a frame, then a clean frame afterwards.
      @(posedge clk); #1;
      txValid[0] = 1'b1;
      txData[0] = 8'h5A;
      waitReady(0);
      @(posedge clk); #1;
      txValid[0] = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      sendWord(0, 8'h3C);
      waitIdle(0);

      // Random producers: an offered word is held until taken, while data
      // wanders freely whenever nothing is offered, including mid-frame.
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         accSeen = txValid & txReady;
         @(posedge clk); #1;
         for (int i = 0; i < NI; i++) begin
            if (accSeen[i] || !txValid[i]) begin
               txValid[i] = ($urandom_range(0, 2) != 0);
               txData[i] = 8'($urandom);
            end
         end
      end
      @(posedge clk); #1;
      txValid = '0;
      for (int i = 0; i < NI; i++) waitIdle(i);
   endtask

   // Reset, run the scenarios and report.
   initial begin
      for (int i = 0; i < NI; i++) txData[i] = 8'h00;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus();
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
